if_id_buffer: RTL and testbench

- Pipeline buffer between the instruction fetch stage and the decoder.
- Captures each fetched instruction word and its PC+4 link address, and holds them while decode is stalled.
- Instruction ROM reads are synchronous (one-cycle latency), so fetch cannot stop instantly. The buffer therefore keeps a small skid FIFO and throttles fetch early.
- On a control-flow redirect (flush) it discards buffered words and the word already in flight, then presents no-ops to decode.

---
 rtl/if_id_buffer_pkg.sv | 17 +
 rtl/sync_fifo_skid.sv | 47 ++++
 rtl/if_id_buffer.sv | 104 ++++++++++
 tb/tb_if_id_buffer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/if_id_buffer_pkg.sv
// Shared definitions for the IF/ID pipeline buffer: default sizes, the nop word
// and the flush-drop state encoding.
package if_id_buffer_pkg;

  localparam int unsigned ISA_WIDTH        = 32;
  localparam int unsigned IF_ID_DEPTH      = 2;
  localparam int unsigned IF_ID_FLUSH_DROP = 1;
  localparam int unsigned IF_ID_CNT_WIDTH  = 16;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0000;

  typedef enum logic {
    NORMAL = 1'b0,
    DROP   = 1'b1
  } drop_state_t;

endpackage

// File: rtl/sync_fifo_skid.sv
// Generic DEPTH-entry register FIFO with occupancy count, synchronous clear and
// asynchronous reset. Head entry is read combinationally from the storage array.
module sync_fifo_skid #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: skid FIFO between fetch and decode with early fetch
// throttling, post-flush drop window, sticky overflow flag and stall counter.
module if_id_buffer #(
  parameter int unsigned ISA_WIDTH  = if_id_buffer_pkg::ISA_WIDTH,
  parameter int unsigned DEPTH      = if_id_buffer_pkg::IF_ID_DEPTH,
  parameter int unsigned FLUSH_DROP = if_id_buffer_pkg::IF_ID_FLUSH_DROP,
  parameter int unsigned CNT_WIDTH  = if_id_buffer_pkg::IF_ID_CNT_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [ISA_WIDTH-1:0] in_instruction,
  input  logic [ISA_WIDTH-1:0] in_link_addr,
  output logic                 in_ready,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [ISA_WIDTH-1:0] out_instruction,
  output logic [ISA_WIDTH-1:0] out_link_addr,
  input  logic                 out_ready,
  output logic                 out_no_op,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] stall_count
);

  import if_id_buffer_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned DW = (FLUSH_DROP > 0) ? $clog2(FLUSH_DROP+1) : 1;

  drop_state_t          state;
  drop_state_t          state_next;
  logic [DW-1:0]        drop_cnt;
  logic                 drop_active;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_next;
  logic                 accept;
  logic                 pop;
  logic                 overflow_cond;
  logic [2*ISA_WIDTH-1:0] head_data;

  // Drop FSM: state register (drop_cnt travels with the state)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= NORMAL;
      drop_cnt <= '0;
    end else begin
      state <= state_next;
      if (flush && FLUSH_DROP > 0) drop_cnt <= DW'(FLUSH_DROP);
      else if (drop_cnt != '0)     drop_cnt <= drop_cnt - DW'(1);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      NORMAL: if (flush && FLUSH_DROP > 0) state_next = DROP;
      DROP:   if (!flush && drop_cnt == DW'(1)) state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
  end

  always_comb begin
    drop_active = (state == DROP);
  end

  assign out_valid     = (count != '0);
  assign out_no_op     = !out_valid;
  assign accept        = in_valid && !drop_active && !flush && (count < CW'(DEPTH));
  assign pop           = out_valid && out_ready && !flush;
  assign overflow_cond = in_valid && !drop_active && !flush && (count == CW'(DEPTH)) && !pop;
  assign count_next    = flush ? '0 : count + CW'(accept) - CW'(pop);

  sync_fifo_skid #(
    .WIDTH (2*ISA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .pop       (pop),
    .clear     (flush),
    .push_data ({in_instruction, in_link_addr}),
    .head_data (head_data),
    .count     (count)
  );

  // One slot stays free for the word already in flight from the synchronous ROM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_ready    <= 1'b1;
      overflow    <= 1'b0;
      stall_count <= '0;
    end else begin
      in_ready <= (count_next <= CW'(DEPTH-2));
      if (overflow_cond) overflow <= 1'b1;
      if (out_valid && !out_ready && stall_count != '1)
        stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end

  assign out_instruction = out_valid ? head_data[2*ISA_WIDTH-1:ISA_WIDTH] : ISA_WIDTH'(NOP_INSTRUCTION);
  assign out_link_addr   = out_valid ? head_data[ISA_WIDTH-1:0]           : '0;

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for if_id_buffer (default parameters).
module tb_if_id_buffer;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_instruction;
  logic [W-1:0] in_link_addr;
  logic         in_ready;
  logic         flush;
  logic         out_valid;
  logic [W-1:0] out_instruction;
  logic [W-1:0] out_link_addr;
  logic         out_ready;
  logic         out_no_op;
  logic         overflow;
  logic [15:0]  stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  if_id_buffer #(
    .ISA_WIDTH  (32),
    .DEPTH      (2),
    .FLUSH_DROP (1),
    .CNT_WIDTH  (16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_instruction  (in_instruction),
    .in_link_addr    (in_link_addr),
    .in_ready        (in_ready),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_instruction (out_instruction),
    .out_link_addr   (out_link_addr),
    .out_ready       (out_ready),
    .out_no_op       (out_no_op),
    .overflow        (overflow),
    .stall_count     (stall_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] lnk,
                     input logic rdy, input logic fl);
    in_valid       = v;
    in_instruction = ins;
    in_link_addr   = lnk;
    out_ready      = rdy;
    flush          = fl;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_instruction = '0; in_link_addr = '0;
    out_ready = 1'b0; flush = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_no_op", out_no_op, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_instr", out_instruction, 0);
    check("rst_link", out_link_addr, 0);
    check("rst_overflow", overflow, 0);
    check("rst_stall", stall_count, 0);
    @(negedge clock);
    reset = 1'b0;

    // Streaming with decode always ready: each word visible right after its accept edge.
    for (int k = 0; k < 4; k++) begin
      cyc(1, 32'h2008_0001 + k, 32'(4 * (k + 1)), 1, 0);
      check("stream_valid", out_valid, 1);
      check("stream_instr", out_instruction, 32'h2008_0001 + k);
      check("stream_link", out_link_addr, 32'(4 * (k + 1)));
      check("stream_in_ready", in_ready, 0);
      check("stream_overflow", overflow, 0);
    end
    cyc(0, 0, 0, 1, 0);
    check("stream_drained", out_valid, 0);
    check("stream_drained_nop", out_instruction, 0);
    check("stream_drained_ready", in_ready, 1);

    // Decode stall with one in-flight word landing in the second entry.
    cyc(1, 32'h1111_1111, 32'h100, 0, 0);
    check("stall_head", out_instruction, 32'h1111_1111);
    check("stall_in_ready", in_ready, 0);
    check("stall_cnt0", stall_count, 0);
    cyc(1, 32'h2222_2222, 32'h104, 0, 0);
    check("stall_in_ready2", in_ready, 0);
    check("stall_cnt1", stall_count, 1);
    repeat (4) cyc(0, 0, 0, 0, 0);
    check("stall_cnt5", stall_count, 5);
    check("stall_overflow", overflow, 0);
    check("stall_head_held", out_instruction, 32'h1111_1111);
    check("stall_link_held", out_link_addr, 32'h100);
    cyc(0, 0, 0, 1, 0);
    check("release_instr", out_instruction, 32'h2222_2222);
    check("release_link", out_link_addr, 32'h104);
    check("release_in_ready", in_ready, 0);
    cyc(0, 0, 0, 1, 0);
    check("release_empty", out_valid, 0);
    check("release_in_ready2", in_ready, 1);
    check("release_stall", stall_count, 5);

    // Flush with two buffered entries and a word arriving in the same cycle.
    cyc(1, 32'hF000_0000, 32'h200, 0, 0);
    cyc(1, 32'hF000_0001, 32'h204, 0, 0);
    check("flush_pre_stall", stall_count, 6);
    cyc(1, 32'hF000_0002, 32'h208, 0, 1);
    check("flush_valid", out_valid, 0);
    check("flush_instr", out_instruction, 0);
    check("flush_link", out_link_addr, 0);
    check("flush_no_op", out_no_op, 1);
    check("flush_in_ready", in_ready, 1);
    check("flush_stall", stall_count, 7);
    cyc(1, 32'hDEAD_BEEF, 32'h20C, 1, 0);
    check("drop_valid", out_valid, 0);
    cyc(1, 32'hF000_0003, 32'h300, 1, 0);
    check("resume_valid", out_valid, 1);
    check("resume_instr", out_instruction, 32'hF000_0003);
    check("resume_link", out_link_addr, 32'h300);
    check("drop_overflow", overflow, 0);
    cyc(0, 0, 0, 1, 0);
    check("resume_drained", out_valid, 0);

    // Flush and pop together with one entry: discarded, not consumed twice.
    cyc(1, 32'h6000_0000, 32'h400, 1, 0);
    check("fp_loaded", out_instruction, 32'h6000_0000);
    cyc(0, 0, 0, 1, 1);
    check("fp_valid", out_valid, 0);
    check("fp_stall", stall_count, 7);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    check("fp_idle", out_valid, 0);

    // Fetch ignores in_ready and pushes into a full buffer.
    cyc(1, 32'h7000_0000, 32'h500, 0, 0);
    cyc(1, 32'h7000_0001, 32'h504, 0, 0);
    check("ovf_pre", overflow, 0);
    cyc(1, 32'h7000_0002, 32'h508, 0, 0);
    check("ovf_set", overflow, 1);
    check("ovf_head", out_instruction, 32'h7000_0000);
    check("ovf_stall", stall_count, 9);
    cyc(0, 0, 0, 0, 0);
    check("ovf_sticky", overflow, 1);
    check("ovf_stall2", stall_count, 10);
    cyc(0, 0, 0, 1, 0);
    check("ovf_second", out_instruction, 32'h7000_0001);
    check("ovf_second_link", out_link_addr, 32'h504);
    cyc(0, 0, 0, 1, 0);
    check("ovf_empty", out_valid, 0);
    check("ovf_sticky2", overflow, 1);

    // Asynchronous reset mid-stall with the buffer full.
    cyc(1, 32'h8000_0000, 32'h600, 0, 0);
    cyc(1, 32'h8000_0001, 32'h604, 0, 0);
    check("ar_full_valid", out_valid, 1);
    check("ar_full_in_ready", in_ready, 0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_stall", stall_count, 0);
    check("ar_overflow", overflow, 0);
    check("ar_no_op", out_no_op, 1);
    check("ar_instr", out_instruction, 0);
    #2;
    reset = 1'b0;
    cyc(0, 0, 0, 1, 0);
    check("ar_after", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
